// File: rtl/id_stage_decoder.sv
// Registered RV32I/RV64I instruction-decode stage with a valid/ready handshake.
// It also handles stall and flush, inserts one bubble on a load-use hazard, and flags illegal instructions.
module id_stage_decoder #(
  parameter int XLEN    = 32,
  parameter bit RV64_EN = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] data_rs1,
  input  logic [XLEN-1:0] data_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_op,
  output logic [XLEN-1:0] out_alu_num1,
  output logic [XLEN-1:0] out_alu_num2,
  output logic [XLEN-1:0] out_jmp_num1,
  output logic [XLEN-1:0] out_jmp_num2,
  output logic [1:0]      out_jmp_flag,
  output logic            out_load_en,
  output logic            out_store_en,
  output logic [2:0]      out_mem_code,
  output logic            out_word_op,
  output logic [4:0]      out_rd,
  output logic            out_wr_en,
  output logic            out_illegal
);

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_FENCE   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [4:0]      rd_f, rs1_f, rs2_f;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign rd_f   = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1_f  = in_instr[19:15];
  assign rs2_f  = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  logic [3:0]      d_op;
  logic [XLEN-1:0] d_n1, d_n2, d_j1, d_j2;
  logic [1:0]      d_jf;
  logic [2:0]      d_mc;
  logic            d_ld, d_st, d_wo, d_wr, d_ill, use1, use2, f7_ok;

  always_comb begin
    d_op  = '0;  d_n1 = '0;  d_n2 = '0;  d_j1 = '0;  d_j2 = '0;
    d_jf  = '0;  d_mc = '0;  d_ld = 1'b0; d_st = 1'b0; d_wo = 1'b0;
    d_wr  = 1'b0; d_ill = 1'b0; use1 = 1'b0; use2 = 1'b0;
    f7_ok = (funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
    case (opcode)
      OPC_LUI:   begin d_n1 = imm_u; d_wr = 1'b1; end
      OPC_AUIPC: begin d_n1 = in_pc; d_n2 = imm_u; d_wr = 1'b1; end
      OPC_JAL: begin
        d_n1 = in_pc; d_n2 = FOUR; d_j1 = in_pc; d_j2 = imm_j; d_jf = 2'd2; d_wr = 1'b1;
      end
      OPC_JALR: begin
        d_ill = (funct3 != 3'b000);
        use1 = 1'b1; d_n1 = in_pc; d_n2 = FOUR; d_j1 = data_rs1; d_j2 = imm_i;
        d_jf = 2'd3; d_wr = 1'b1;
      end
      OPC_BRANCH: begin
        d_ill = (funct3[2:1] == 2'b01);
        use1 = 1'b1; use2 = 1'b1; d_op = {1'b0, funct3};
        d_n1 = data_rs1; d_n2 = data_rs2; d_j1 = in_pc; d_j2 = imm_b; d_jf = 2'd1;
      end
      OPC_LOAD: begin
        // LD and LWU exist only on RV64
        d_ill = (funct3 == 3'b111) || (!RV64_EN && (funct3 == 3'b011 || funct3 == 3'b110));
        use1 = 1'b1; d_n1 = data_rs1; d_n2 = imm_i; d_ld = 1'b1; d_mc = funct3; d_wr = 1'b1;
      end
      OPC_STORE: begin
        d_ill = funct3[2] || (!RV64_EN && funct3 == 3'b011);
        use1 = 1'b1; use2 = 1'b1; d_n1 = data_rs1; d_n2 = imm_s; d_st = 1'b1; d_mc = funct3;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        d_ill = (opcode == OPC_OPIMM32) && !RV64_EN;
        d_wo  = (opcode == OPC_OPIMM32);
        use1 = 1'b1; d_op = {(funct3 == 3'b101) && in_instr[30], funct3};
        d_n1 = data_rs1; d_n2 = imm_i; d_wr = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        d_ill = !f7_ok || ((opcode == OPC_OP32) && !RV64_EN);
        d_wo  = (opcode == OPC_OP32);
        use1 = 1'b1; use2 = 1'b1; d_op = {in_instr[30], funct3};
        d_n1 = data_rs1; d_n2 = data_rs2; d_wr = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: d_ill = 1'b1;
    endcase
    // an illegal instruction travels as an inert payload with only the flag set
    if (d_ill) begin
      d_op = '0; d_n1 = '0; d_n2 = '0; d_j1 = '0; d_j2 = '0; d_jf = '0; d_mc = '0;
      d_ld = 1'b0; d_st = 1'b0; d_wo = 1'b0; d_wr = 1'b0; use1 = 1'b0; use2 = 1'b0;
    end
  end

  logic hazard, accept;

  assign rs1_addr = use1 ? rs1_f : 5'd0;
  assign rs2_addr = use2 ? rs2_f : 5'd0;
  assign hazard   = out_valid && out_load_en && (out_rd != 5'd0) && in_valid &&
                    ((rs1_addr == out_rd) || (rs2_addr == out_rd));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_alu_op   <= '0;
      out_alu_num1 <= '0;
      out_alu_num2 <= '0;
      out_jmp_num1 <= '0;
      out_jmp_num2 <= '0;
      out_jmp_flag <= '0;
      out_load_en  <= 1'b0;
      out_store_en <= 1'b0;
      out_mem_code <= '0;
      out_word_op  <= 1'b0;
      out_rd       <= '0;
      out_wr_en    <= 1'b0;
      out_illegal  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= accept;
      if (accept) begin
        out_alu_op   <= d_op;
        out_alu_num1 <= d_n1;
        out_alu_num2 <= d_n2;
        out_jmp_num1 <= d_j1;
        out_jmp_num2 <= d_j2;
        out_jmp_flag <= d_jf;
        out_load_en  <= d_ld;
        out_store_en <= d_st;
        out_mem_code <= d_mc;
        out_word_op  <= d_wo;
        out_rd       <= d_wr ? rd_f : 5'd0;
        out_wr_en    <= d_wr && (rd_f != 5'd0);
        out_illegal  <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_decoder.sv
// Self-checking bench for id_stage_decoder (XLEN = 64, RV64_EN = 0): directed scenarios
// followed by a randomized stream checked against a mnemonic-level reference decoder.
module tb_id_stage_decoder;
  localparam int XLEN = 64;
  localparam bit RV64 = 1'b0;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0, data_rs1 = '0, data_rs2 = '0;
  logic in_ready, out_valid, out_load_en, out_store_en, out_word_op, out_wr_en, out_illegal;
  logic [4:0] rs1_addr, rs2_addr, out_rd;
  logic [3:0] out_alu_op;
  logic [63:0] out_alu_num1, out_alu_num2, out_jmp_num1, out_jmp_num2;
  logic [1:0] out_jmp_flag;
  logic [2:0] out_mem_code;

  id_stage_decoder #(.XLEN(XLEN), .RV64_EN(RV64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .data_rs1(data_rs1),
    .data_rs2(data_rs2), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_op(out_alu_op), .out_alu_num1(out_alu_num1), .out_alu_num2(out_alu_num2),
    .out_jmp_num1(out_jmp_num1), .out_jmp_num2(out_jmp_num2), .out_jmp_flag(out_jmp_flag),
    .out_load_en(out_load_en), .out_store_en(out_store_en), .out_mem_code(out_mem_code),
    .out_word_op(out_word_op), .out_rd(out_rd), .out_wr_en(out_wr_en), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] n1, n2, j1, j2;
    logic [1:0]  jf;
    logic        ld, st;
    logic [2:0]  mc;
    logic        wo;
    logic [4:0]  rd;
    logic        we, ill;
  } pay_t;

  pay_t obs;
  assign obs = {out_alu_op, out_alu_num1, out_alu_num2, out_jmp_num1, out_jmp_num2, out_jmp_flag,
                out_load_en, out_store_en, out_mem_code, out_word_op, out_rd, out_wr_en, out_illegal};

  int passed = 0, total = 0;

  // Reference decoder written instruction class by instruction class.
  function automatic void ref_decode(input logic [31:0] ins, input logic [63:0] pc, d1, d2,
                                     output pay_t p, output logic [4:0] a1, output logic [4:0] a2);
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    logic [63:0] imm_i = 64'($signed(ins[31:20]));
    logic [63:0] imm_s = 64'($signed({ins[31:25], ins[11:7]}));
    logic [63:0] imm_b = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    logic [63:0] imm_u = 64'($signed({ins[31:12], 12'h000}));
    logic [63:0] imm_j = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    logic writes = 1'b0, bad = 1'b0;
    p = '0; a1 = ins[19:15]; a2 = ins[24:20];
    case (ins[6:0])
      7'b0110111: begin p.n1 = imm_u; writes = 1; a1 = 0; a2 = 0; end
      7'b0010111: begin p.n1 = pc; p.n2 = imm_u; writes = 1; a1 = 0; a2 = 0; end
      7'b1101111: begin p.n1 = pc; p.n2 = 4; p.j1 = pc; p.j2 = imm_j; p.jf = 2; writes = 1; a1 = 0; a2 = 0; end
      7'b1100111: begin bad = (f3 != 0); p.n1 = pc; p.n2 = 4; p.j1 = d1; p.j2 = imm_i; p.jf = 3; writes = 1; a2 = 0; end
      7'b1100011: begin bad = (f3 == 2 || f3 == 3); p.op = {1'b0, f3}; p.n1 = d1; p.n2 = d2; p.j1 = pc; p.j2 = imm_b; p.jf = 1; end
      7'b0000011: begin
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (RV64 && f3 inside {3'd3, 3'd6}));
        p.n1 = d1; p.n2 = imm_i; p.ld = 1; p.mc = f3; writes = 1; a2 = 0;
      end
      7'b0100011: begin
        bad = !(f3 inside {3'd0, 3'd1, 3'd2} || (RV64 && f3 == 3));
        p.n1 = d1; p.n2 = imm_s; p.st = 1; p.mc = f3;
      end
      7'b0010011, 7'b0011011: begin
        bad = (ins[3] && !RV64); p.wo = ins[3];
        p.op = {(f3 == 5) ? ins[30] : 1'b0, f3}; p.n1 = d1; p.n2 = imm_i; writes = 1; a2 = 0;
      end
      7'b0110011, 7'b0111011: begin
        bad = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) || (ins[3] && !RV64);
        p.wo = ins[3]; p.op = {ins[30], f3}; p.n1 = d1; p.n2 = d2; writes = 1;
      end
      7'b0001111, 7'b1110011: begin a1 = 0; a2 = 0; end
      default: bad = 1;
    endcase
    if (bad) begin p = '0; p.ill = 1; a1 = 0; a2 = 0; end
    else if (writes) begin p.rd = ins[11:7]; p.we = (ins[11:7] != 0); end
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 13))
      0: r[6:0] = 7'h37;  1: r[6:0] = 7'h17;  2: r[6:0] = 7'h6f;  3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;  5: r[6:0] = 7'h03;  6: r[6:0] = 7'h23;  7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h1b;  9: r[6:0] = 7'h33;  10: r[6:0] = 7'h3b; 11: r[6:0] = 7'h0f;
      12: r[6:0] = 7'h73; default: ;
    endcase
    r[11:7] = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    if (r[6:0] inside {7'h33, 7'h3b} && $urandom_range(0, 3) != 0)
      r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if (r[6:0] == 7'h67 && $urandom_range(0, 3) != 0) r[14:12] = 3'b000;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 0; flush = 0;
    repeat (2) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", in_ready); else passed++;
    total++; if (obs !== '0) $display("FAIL reset_payload got=%h exp=0", obs); else passed++;
    rst_n = 1; in_instr = 32'hFFF00293; in_valid = 1; data_rs1 = 0;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL midrst_setup got=%b exp=1", out_valid); else passed++;
    in_valid = 0; #2 rst_n = 0; #1;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_async_valid got=%b exp=0", out_valid); else passed++;
    total++; if (obs !== '0) $display("FAIL midrst_payload got=%h exp=0", obs); else passed++;
    #1 rst_n = 1;
    tick();
    total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL midrst_after_valid got=%b exp=0", out_valid); else passed++;
  endtask

  task automatic test_addi();
    out_ready = 1; in_valid = 1; in_instr = 32'hFFF00293; in_pc = 64'h40; data_rs1 = 0;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got=%b exp=1", out_valid); else passed++;
    total++; if (out_alu_num2 !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL addi_num2 got=%h exp=ffffffffffffffff", out_alu_num2); else passed++;
    total++; if (out_rd !== 5'd5 || out_wr_en !== 1'b1) $display("FAIL addi_rd got=%0d/%b exp=5/1", out_rd, out_wr_en); else passed++;
    total++; if (out_alu_op !== 4'b0000) $display("FAIL addi_op got=%b exp=0000", out_alu_op); else passed++;
    tick();
  endtask

  task automatic test_load_use(input logic use_flush);
    out_ready = 1; in_valid = 1; in_instr = 32'h0000A303; in_pc = 64'h200; data_rs1 = 64'h1000; data_rs2 = 64'h22;
    tick();
    total++; if (out_valid !== 1'b1 || out_load_en !== 1'b1 || out_rd !== 5'd6)
      $display("FAIL lu_load got=%b/%b/%0d exp=1/1/6", out_valid, out_load_en, out_rd); else passed++;
    in_instr = 32'h002303B3; in_pc = 64'h204; data_rs1 = 64'h77; flush = use_flush;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL lu_stall_ready got=%b exp=0", in_ready); else passed++;
    total++; if (rs1_addr !== 5'd6 || rs2_addr !== 5'd2) $display("FAIL lu_rsaddr got=%0d/%0d exp=6/2", rs1_addr, rs2_addr); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL lu_bubble got=%b exp=0", out_valid); else passed++;
    if (use_flush) begin
      flush = 0; in_valid = 0;
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL flush_dropped got=%b exp=0", out_valid); else passed++;
    end else begin
      @(negedge clk);
      total++; if (in_ready !== 1'b1) $display("FAIL lu_resume_ready got=%b exp=1", in_ready); else passed++;
      tick();
      in_valid = 0;
      total++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_alu_num1 !== 64'h77 || out_alu_num2 !== 64'h22)
        $display("FAIL lu_add got=%b/%0d/%h/%h exp=1/7/77/22", out_valid, out_rd, out_alu_num1, out_alu_num2); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    pay_t e; logic [4:0] a1, a2;
    out_ready = 1; in_valid = 1; in_instr = 32'hFE208CE3; in_pc = 64'h100; data_rs1 = 64'h5; data_rs2 = 64'h9;
    ref_decode(in_instr, in_pc, data_rs1, data_rs2, e, a1, a2);
    tick();
    out_ready = 0; in_instr = 32'h00100093; in_pc = 64'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%b exp=0", i, in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1 || obs !== e) $display("FAIL bp_hold[%0d] got=%h exp=%h", i, obs, e); else passed++;
    end
    total++; if (out_jmp_num2 !== 64'hFFFF_FFFF_FFFF_FFF8 || out_jmp_flag !== 2'd1 || out_jmp_num1 !== 64'h100)
      $display("FAIL bp_branch got=%h/%0d/%h exp=fffffffffffffff8/1/100", out_jmp_num2, out_jmp_flag, out_jmp_num1); else passed++;
    out_ready = 1;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_jmp_flag !== 2'd0)
      $display("FAIL bp_release got=%b/%0d/%0d exp=1/1/0", out_valid, out_rd, out_jmp_flag); else passed++;
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1; in_valid = 1; in_instr = 32'hFFFFFFFF;
    tick();
    in_instr = 32'h0000B403;
    total++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_wr_en !== 1'b0)
      $display("FAIL ill_ones got=%b/%b/%b exp=1/1/0", out_valid, out_illegal, out_wr_en); else passed++;
    @(negedge clk);
    total++; if (rs1_addr !== 5'd0) $display("FAIL ill_ld_rs1 got=%0d exp=0", rs1_addr); else passed++;
    tick();
    in_valid = 0;
    total++; if (out_illegal !== 1'b1 || out_wr_en !== 1'b0 || out_load_en !== 1'b0 || out_rd !== 5'd0)
      $display("FAIL ill_ld got=%b/%b/%b/%0d exp=1/0/0/0", out_illegal, out_wr_en, out_load_en, out_rd); else passed++;
    tick();
  endtask

  task automatic test_random();
    pay_t e, exp_p = '0; logic [4:0] a1, a2; logic exp_valid = 0, haz, rdy, acc;
    out_ready = 1; in_valid = 0; flush = 0;
    tick();
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 3) != 0); out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0); in_instr = gen_instr();
      in_pc = {$urandom, $urandom} & ~64'h3; data_rs1 = {$urandom, $urandom}; data_rs2 = {$urandom, $urandom};
      ref_decode(in_instr, in_pc, data_rs1, data_rs2, e, a1, a2);
      haz = exp_valid && exp_p.ld && exp_p.rd != 0 && in_valid && (a1 == exp_p.rd || a2 == exp_p.rd);
      rdy = !flush && !haz && (!exp_valid || out_ready);
      @(negedge clk);
      total++; if (rs1_addr !== a1 || rs2_addr !== a2) $display("FAIL rnd_rsaddr[%0d] got=%0d/%0d exp=%0d/%0d", c, rs1_addr, rs2_addr, a1, a2); else passed++;
      total++; if (in_ready !== rdy) $display("FAIL rnd_ready[%0d] got=%b exp=%b instr=%h", c, in_ready, rdy, in_instr); else passed++;
      acc = in_valid && rdy;
      if (flush) exp_valid = 0;
      else if (!exp_valid || out_ready) begin exp_valid = acc; if (acc) exp_p = e; end
      tick();
      total++; if (out_valid !== exp_valid) $display("FAIL rnd_valid[%0d] got=%b exp=%b", c, out_valid, exp_valid); else passed++;
      if (exp_valid) begin
        total++; if (obs !== exp_p) $display("FAIL rnd_payload[%0d] got=%h exp=%h", c, obs, exp_p); else passed++;
      end
    end
    in_valid = 0; flush = 0; out_ready = 1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_load_use(1'b0);
    test_backpressure();
    test_load_use(1'b1);
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
